seq_bin_to_bcd: RTL and testbench
=================================

# seq_bin_to_bcd

Sequential double-dabble converter that turns the 16-bit product from the Booth multiplier into packed BCD digits for the 7-segment display controller. It sits directly downstream of the multiplier. It accepts one word per start pulse and iterates one bit per two clock cycles (adjust, then shift). It signals completion with a one-cycle done strobe, and its BCD output register holds the last result until the next conversion completes.

## Interface
- WIDTH, 16, binary input width in bits.
- DIGITS, 5, number of BCD output digits; 10^DIGITS must exceed 2^WIDTH − 1.
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  conversion request; sampled only in IDLE.
- bin_i  input  WIDTH  binary value; captured in the cycle start_i is accepted.
- bcd_o  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0]. Reset value 0.
- neg_o  output  1  sign of converted value. Reset value 0.
- busy_o  output  1  high whenever state ≠ IDLE. Reset value 0.
- done_o  output  1  one-cycle strobe: bcd_o/neg_o just updated. Reset value 0.

## Operation
- Internal registers:
  - shift register {bcd_acc[4*DIGITS-1:0], bin_acc[WIDTH-1:0]};
  - bit counter, width ceil(log2(WIDTH+1));
  - sign flag.
- FSM states: IDLE, ADJUST, SHIFT, DONE.
- IDLE: if start_i, then:
  - bin_acc ← magnitude(bin_i), bcd_acc ← 0, counter ← WIDTH, sign flag ← sign(bin_i);
  - go to ADJUST.
  - Otherwise stay in IDLE.
- ADJUST: every nibble of bcd_acc ≥ 5 gets +3, applied to all nibbles in parallel. Go to SHIFT.
- SHIFT:
  - shift {bcd_acc, bin_acc} left by 1; counter ← counter − 1;
  - if counter was 1, go to DONE; otherwise go to ADJUST.
- DONE: done_o = 1 for this cycle. Go to IDLE.
- bcd_o ← bcd_acc and neg_o ← sign flag are loaded on the edge entering DONE. Both hold until the next entry into DONE.
- start_i while busy_o = 1 is ignored; no queuing and no effect on the conversion in flight.
- Magnitude is computed in WIDTH bits, unsigned. The most negative value −2^(WIDTH−1) therefore converts correctly as 2^(WIDTH−1).
- Nibble values above 9 never appear in bcd_o for legal parameters.

## Timing
- start_i sampled high in IDLE at cycle 0. ADJUST/SHIFT alternate over cycles 1..2*WIDTH.
- DONE occurs at cycle 2*WIDTH+1, i.e. cycle 33 for WIDTH = 16.
- busy_o is high for cycles 1..2*WIDTH+1. done_o is high only in cycle 2*WIDTH+1.
- The earliest next accepted start is cycle 2*WIDTH+2, giving throughput of one conversion per 2*WIDTH+2 cycles.
- start_i held high continuously restarts in the first IDLE cycle after each DONE.
- rst asserted in any state, including mid-conversion, has the following effect at the next edge:
  - state → IDLE;
  - all outputs → reset values;
  - accumulators and counter → 0;
  - no done_o is produced for the aborted conversion.
- rst and start_i high together: reset wins.

## Configuration
- SIGNED_INPUT_EN defined:
  - bin_i is two's complement; magnitude = bin_i[WIDTH-1] ? −bin_i : bin_i;
  - neg_o follows bin_i[WIDTH-1];
  - a zero result always reports neg_o = 0.
- SIGNED_INPUT_EN undefined:
  - bin_i is unsigned and converted directly;
  - sign flag is tied 0, so neg_o is constant 0;
  - negation logic is absent.

## Test plan
- Reset, then bin_i = 0 with start_i pulse → done_o at cycle 33; bcd_o = 0x00000, neg_o = 0.
- Without SIGNED_INPUT_EN, bin_i = 0xFFFF → bcd_o = 0x65535, neg_o = 0. With the macro, the same input → bcd_o = 0x00001, neg_o = 1.
- With SIGNED_INPUT_EN, bin_i = 0x8000 → bcd_o = 0x32768, neg_o = 1. With the macro, bin_i = 0x04D2 → bcd_o = 0x01234, neg_o = 0.
- Start with 0x0063 (bcd_o = 0x00099); pulse start_i with 0x1111 at cycle 10 while busy → result still 0x00099; exactly one done_o; busy_o low at cycle 34.
- Start a conversion, assert rst at cycle 15 → next cycle busy_o = 0, bcd_o = 0, no done_o. A fresh start with 0x0007 → bcd_o = 0x00007 after 33 cycles.
- start_i held high with a changing bin_i → back-to-back results every 34 cycles. Each result matches the bin_i value present on its acceptance cycle.

Source files
------------

// File: rtl/seq_bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per adjust/shift pair.
// Define SIGNED_INPUT_EN to treat bin_i as two's complement and report the sign on neg_o.
module seq_bin_to_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [WIDTH-1:0]    bin_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                neg_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    ADJUST,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [BW-1:0]    bcd_acc;
  logic [WIDTH-1:0] bin_acc;
  logic [CW-1:0]    cnt;
  logic             sign_q;

  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_shift;
  logic [WIDTH-1:0] mag;
  logic             sign_next;
  logic [3:0]       nib;
  logic             last_bit;

  assign last_bit  = (cnt == CW'(1));
  assign bcd_shift = {bcd_acc[BW-2:0], bin_acc[WIDTH-1]};
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);

`ifdef SIGNED_INPUT_EN
  always_comb begin
    mag       = bin_i[WIDTH-1] ? -bin_i : bin_i;
    sign_next = bin_i[WIDTH-1] && (mag != '0);
  end
`else
  always_comb begin
    mag       = bin_i;
    sign_next = 1'b0;
  end
`endif

  // Every nibble at 5 or above gets +3 so the following shift carries correctly into the next digit.
  always_comb begin
    bcd_adj = bcd_acc;
    nib     = '0;
    for (int d = 0; d < DIGITS; d++) begin
      nib = bcd_acc[4*d +: 4];
      bcd_adj[4*d +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = ADJUST;
      ADJUST:  state_next = SHIFT;
      SHIFT:   state_next = last_bit ? DONE : ADJUST;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_acc <= '0;
      bin_acc <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      bcd_o   <= '0;
      neg_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            bcd_acc <= '0;
            bin_acc <= mag;
            cnt     <= CW'(WIDTH);
            sign_q  <= sign_next;
          end
        end
        ADJUST: bcd_acc <= bcd_adj;
        SHIFT: begin
          bcd_acc <= bcd_shift;
          bin_acc <= {bin_acc[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          // Result registers update only on the final shift, i.e. the edge entering DONE.
          if (last_bit) begin
            bcd_o <= bcd_shift;
            neg_o <= sign_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Directed self-checking bench for seq_bin_to_bcd; expectations follow SIGNED_INPUT_EN when defined.
module tb_seq_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] bin_i = '0;
  logic [19:0] bcd_o;
  logic        neg_o;
  logic        busy_o;
  logic        done_o;

  int total = 0;
  int bad = 0;

  seq_bin_to_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .bin_i(bin_i),
    .bcd_o(bcd_o),
    .neg_o(neg_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts v at cycle 0 and returns the cycle in which done_o rose (100 on timeout).
  task automatic run_conv(input logic [15:0] v, output int lat);
    start_i = 1'b1;
    bin_i   = v;
    step();
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    step();
    step();
    total++; if (bcd_o !== 20'h0) begin bad++; $display("[TB] FAIL reset_bcd got=%h want=%h", bcd_o, 20'h0); end
    total++; if (neg_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_neg got=%b want=0", neg_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_values();
    logic [15:0] ins [6];
    logic [19:0] exp_bcd [6];
    logic        exp_neg [6];
    int lat;
    ins = '{16'h0000, 16'hFFFF, 16'h8000, 16'h04D2, 16'h270F, 16'h0063};
`ifdef SIGNED_INPUT_EN
    exp_bcd = '{20'h00000, 20'h00001, 20'h32768, 20'h01234, 20'h09999, 20'h00099};
    exp_neg = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp_bcd = '{20'h00000, 20'h65535, 20'h32768, 20'h01234, 20'h09999, 20'h00099};
    exp_neg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 6; i++) begin
      run_conv(ins[i], lat);
      total++; if (lat !== 33) begin bad++; $display("[TB] FAIL latency in=%h got=%0d want=33", ins[i], lat); end
      total++; if (bcd_o !== exp_bcd[i]) begin bad++; $display("[TB] FAIL bcd in=%h got=%h want=%h", ins[i], bcd_o, exp_bcd[i]); end
      total++; if (neg_o !== exp_neg[i]) begin bad++; $display("[TB] FAIL neg in=%h got=%b want=%b", ins[i], neg_o, exp_neg[i]); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("[TB] FAIL busy_in_done in=%h got=%b want=1", ins[i], busy_o); end
      step();
      total++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("[TB] FAIL idle_after in=%h busy=%b done=%b want 0/0", ins[i], busy_o, done_o); end
    end
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    int done_cyc = -1;
    start_i = 1'b1;
    bin_i   = 16'h0063;
    step();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 10) begin
        start_i = 1'b1;
        bin_i   = 16'h1111;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        dones++;
        done_cyc = cyc;
      end
      if (cyc == 34) begin
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL busy_at_34 got=%b want=0", busy_o); end
      end
      step();
    end
    total++; if (dones !== 1) begin bad++; $display("[TB] FAIL done_count got=%0d want=1", dones); end
    total++; if (done_cyc !== 33) begin bad++; $display("[TB] FAIL done_cycle got=%0d want=33", done_cyc); end
    total++; if (bcd_o !== 20'h00099) begin bad++; $display("[TB] FAIL ignored_start_bcd got=%h want=%h", bcd_o, 20'h00099); end
  endtask

  task automatic test_rst_abort();
    int dones = 0;
    int lat;
    start_i = 1'b1;
    bin_i   = 16'h1234;
    step();
    start_i = 1'b0;
    for (int cyc = 1; cyc < 15; cyc++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy_o); end
    total++; if (bcd_o !== 20'h0) begin bad++; $display("[TB] FAIL abort_bcd got=%h want=%h", bcd_o, 20'h0); end
    total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL abort_done got=%b want=0", done_o); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done_o) dones++;
      step();
    end
    total++; if (dones !== 0) begin bad++; $display("[TB] FAIL abort_no_done got=%0d want=0", dones); end
    rst = 1'b1;
    start_i = 1'b1;
    bin_i = 16'h0042;
    step();
    rst = 1'b0;
    start_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_beats_start got=%b want=0", busy_o); end
    run_conv(16'h0007, lat);
    total++; if (lat !== 33) begin bad++; $display("[TB] FAIL fresh_latency got=%0d want=33", lat); end
    total++; if (bcd_o !== 20'h00007) begin bad++; $display("[TB] FAIL fresh_bcd got=%h want=%h", bcd_o, 20'h00007); end
    step();
  endtask

  task automatic test_back_to_back();
    int done_cycs [$];
    logic [19:0] results [$];
    // Acceptances at cycles 0, 34, 68 see bin_i = 5, 1263, 2521.
    for (int cyc = 0; cyc <= 105; cyc++) begin
      start_i = 1'b1;
      bin_i   = 16'(cyc * 37 + 5);
      if (done_o) begin
        done_cycs.push_back(cyc);
        results.push_back(bcd_o);
      end
      step();
    end
    start_i = 1'b0;
    total++; if (done_cycs.size() !== 3) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=3", done_cycs.size()); end
    if (done_cycs.size() == 3) begin
      total++; if (done_cycs[0] !== 33 || done_cycs[1] !== 67 || done_cycs[2] !== 101) begin
        bad++; $display("[TB] FAIL b2b_cycles got=%0d,%0d,%0d want=33,67,101", done_cycs[0], done_cycs[1], done_cycs[2]);
      end
      total++; if (results[0] !== 20'h00005) begin bad++; $display("[TB] FAIL b2b_res0 got=%h want=%h", results[0], 20'h00005); end
      total++; if (results[1] !== 20'h01263) begin bad++; $display("[TB] FAIL b2b_res1 got=%h want=%h", results[1], 20'h01263); end
      total++; if (results[2] !== 20'h02521) begin bad++; $display("[TB] FAIL b2b_res2 got=%h want=%h", results[2], 20'h02521); end
    end
  endtask

  initial begin
    step();
    test_reset();
    test_values();
    test_busy_ignore();
    test_rst_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
